wash_sequencer: RTL and testbench
=================================

Name: wash_sequencer

Overview:
- Master controller for the washing-machine phase timers.
- Drives a level Start to each phase module (fill, wash, drain, rinse, spin, dry) and consumes each module's one-cycle done pulse, for example the dry timer's T2d.
- Sequences a full cycle, pauses on door open, and flags a fault when a phase never reports done.
- Sits above the phase timers; it is the initiator for which they are responders.

Parameters:
- RINSE_COUNT, 2, number of rinse+drain repetitions after the wash drain (1..7).
- TIMEOUT, 1023, watchdog limit in CLK cycles per phase; must exceed the longest phase, which is 601 cycles for dry.
- TW, 10, watchdog counter width; must satisfy 2**TW > TIMEOUT.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Go  input  1  start-cycle request; sampled only in IDLE.
- NoDry  input  1  skip the dry phase; sampled with Go.
- DoorOpen  input  1  door switch level; 1 = open.
- PhaseDone  input  6  done pulses; index 0 FILL, 1 WASH, 2 DRAIN, 3 RINSE, 4 SPIN, 5 DRY.
- PhaseStart  output  6  level Start to each phase module; at most one bit high.
- Busy  output  1  high in any state except IDLE and FAULT.
- Paused  output  1  high in PAUSE.
- CycleDone  output  1  one-cycle pulse when a cycle completes.
- Fault  output  1  sticky watchdog fault.
- State  output  4  current state encoding, for debug and display.

Behaviour:
- Reset (sync, high):
  - State=IDLE; PhaseStart=0, Busy=0, Paused=0, CycleDone=0, Fault=0.
  - Rinse counter=0, watchdog=0, skip-dry flag=0.
  - Reset mid-cycle aborts immediately. All PhaseStart drop on the next edge, which also clears the phase timers because their Start is an active-low clear.
- States: IDLE, FILL, WASH, DRAIN1, RINSE, DRAIN2, SPIN, DRY, FINISH, PAUSE, FAULT.
- Transitions:
  - IDLE, Go=1 and DoorOpen=0 → FILL. Latch NoDry; load rinse counter = RINSE_COUNT.
  - IDLE, Go=1 and DoorOpen=1 → ignored; stay in IDLE.
  - FILL → WASH → DRAIN1 → RINSE → DRAIN2.
  - DRAIN2: if the rinse counter after decrement is >0 → RINSE; else → SPIN. The counter decrements on DRAIN2 done.
  - SPIN → DRY, or → FINISH if the skip-dry flag is set.
  - DRY → FINISH.
  - FINISH lasts one cycle, pulses CycleDone=1, then → IDLE.
- PhaseStart mapping: FILL=bit0, WASH=bit1, DRAIN1 and DRAIN2=bit2, RINSE=bit3, SPIN=bit4, DRY=bit5. A phase's bit is high for every cycle the state is active.
- Advance timing:
  - Advance only on PhaseDone[active bit]=1. Done bits of inactive phases are ignored.
  - Done seen on edge n → on edge n+1 the old bit falls and the new bit rises.
  - Latency from done to the next Start is 1 cycle.
- Watchdog:
  - Cleared on every state entry; increments each cycle while a phase is active and not paused.
  - When it reaches TIMEOUT with no done → FAULT: PhaseStart=0, Fault=1, Busy=0.
  - FAULT exits only on Reset.
- Pause:
  - DoorOpen=1 in any phase state → PAUSE. Remember the phase; PhaseStart=0, Paused=1, Busy stays 1, watchdog holds.
  - DoorOpen=0 in PAUSE → return to the remembered phase with the watchdog cleared. The phase restarts from zero, because Start was dropped.
  - The rinse counter is untouched by pause.
- Simultaneous events:
  - Active done with DoorOpen=1 in the same cycle: the done wins; advance, then pause on the following cycle if the door is still open.
  - Active done on the same cycle the watchdog hits TIMEOUT: the done wins.
  - Go outside IDLE is ignored.
- Arithmetic: the rinse counter is 3 bits. The watchdog is TW bits and saturates at TIMEOUT.

Decomposition:
- Package wash_pkg:
  - State encoding localparams.
  - Phase index constants PH_FILL..PH_DRY.
  - Phase count = 6.
- One sub-module: phase_watchdog. It holds the TW-bit counter with clear, enable and hold inputs and produces a timeout flag; it is instantiated once.

Test Plan:
- Nominal cycle:
  - Stimulus: RINSE_COUNT=2; Go at cycle 5; a responder model pulses done 20 cycles after each Start rises.
  - Required: Start order bits 0,1,2,3,2,3,2,4,5; each rise 1 cycle after the previous done; CycleDone pulses once; Busy falls the cycle after.
- NoDry=1 with Go:
  - Required: bit 5 never rises; FINISH follows SPIN done.
- DoorOpen during WASH:
  - Stimulus: DoorOpen=1 at cycle 10 of WASH, held 15 cycles.
  - Required: PhaseStart=0 and Paused=1 for 15 cycles; bit1 re-rises on the cycle after close; a done 20 cycles later advances to DRAIN1.
- Watchdog:
  - Stimulus: TIMEOUT=50; the responder never answers SPIN.
  - Required: after 50 cycles, Fault=1 and PhaseStart=0; Go is ignored until Reset.
- Stray and simultaneous events:
  - A DRY done during FILL → ignored.
  - FILL done with DoorOpen=1 in the same cycle → WASH entered, then PAUSE next cycle.
- Reset during RINSE:
  - Required: next edge State=IDLE, all outputs 0; a fresh Go restarts at FILL with the rinse count reloaded.

Source files
------------

// File: rtl/wash_sequencer_pkg.sv
// Shared types and constants for the washing-machine master sequencer.
// State encodings double as the debug State output value.
package wash_pkg;

   localparam int PHASES   = 6;
   localparam int PH_FILL  = 0;
   localparam int PH_WASH  = 1;
   localparam int PH_DRAIN = 2;
   localparam int PH_RINSE = 3;
   localparam int PH_SPIN  = 4;
   localparam int PH_DRY   = 5;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_FILL   = 4'd1;
   localparam logic [3:0] ST_WASH   = 4'd2;
   localparam logic [3:0] ST_DRAIN1 = 4'd3;
   localparam logic [3:0] ST_RINSE  = 4'd4;
   localparam logic [3:0] ST_DRAIN2 = 4'd5;
   localparam logic [3:0] ST_SPIN   = 4'd6;
   localparam logic [3:0] ST_DRY    = 4'd7;
   localparam logic [3:0] ST_FINISH = 4'd8;
   localparam logic [3:0] ST_PAUSE  = 4'd9;
   localparam logic [3:0] ST_FAULT  = 4'd10;

   typedef enum logic [3:0] {
      IDLE   = ST_IDLE,
      FILL   = ST_FILL,
      WASH   = ST_WASH,
      DRAIN1 = ST_DRAIN1,
      RINSE  = ST_RINSE,
      DRAIN2 = ST_DRAIN2,
      SPIN   = ST_SPIN,
      DRY    = ST_DRY,
      FINISH = ST_FINISH,
      PAUSE  = ST_PAUSE,
      FAULT  = ST_FAULT
   } state_t;

   // Both drain states share the single drain timer.
   function automatic logic [PHASES-1:0] phaseMask(input state_t s);
      logic [PHASES-1:0] m;
      m = '0;
      case (s)
         FILL:           m[PH_FILL]  = 1'b1;
         WASH:           m[PH_WASH]  = 1'b1;
         DRAIN1, DRAIN2: m[PH_DRAIN] = 1'b1;
         RINSE:          m[PH_RINSE] = 1'b1;
         SPIN:           m[PH_SPIN]  = 1'b1;
         DRY:            m[PH_DRY]   = 1'b1;
         default:        m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Control, status and phase Start/done handshake between the sequencer
// (master) and the machine side: phase timers plus front panel (slave).
interface wash_if;

   logic                        Go;
   logic                        NoDry;
   logic                        DoorOpen;
   logic [wash_pkg::PHASES-1:0] PhaseDone;
   logic [wash_pkg::PHASES-1:0] PhaseStart;
   logic                        Busy;
   logic                        Paused;
   logic                        CycleDone;
   logic                        Fault;
   logic [3:0]                  State;

   modport master (
      input  Go, NoDry, DoorOpen, PhaseDone,
      output PhaseStart, Busy, Paused, CycleDone, Fault, State
   );

   modport slave (
      output Go, NoDry, DoorOpen, PhaseDone,
      input  PhaseStart, Busy, Paused, CycleDone, Fault, State
   );

endinterface

// File: rtl/wash_sequencer_phase_watchdog.sv
// Per-phase watchdog: counts active, unpaused cycles and saturates at TIMEOUT.
// The flag marks the cycle in which the count reaches TIMEOUT.
module phase_watchdog #(
   parameter int TIMEOUT = 1023,
   parameter int TW      = 10
) (
   input  logic CLK,
   input  logic Reset,
   input  logic clear,
   input  logic enable,
   input  logic hold,
   output logic timeout
);

   logic [TW-1:0] count;

   always_ff @(posedge CLK) begin
      if (Reset || clear)
         count <= '0;
      else if (enable && !hold && count != TW'(TIMEOUT))
         count <= count + 1'b1;
   end

   assign timeout = enable && !hold && (count >= TW'(TIMEOUT - 1));

endmodule

// File: rtl/wash_sequencer.sv
// Master sequencer: steps the phase timers through a full wash cycle,
// pausing while the door is open and faulting when a phase never finishes.
module wash_sequencer
   import wash_pkg::*;
#(
   parameter int RINSE_COUNT = 2,
   parameter int TIMEOUT     = 1023,
   parameter int TW          = 10
) (
   input logic    CLK,
   input logic    Reset,
   wash_if.master bus
);

   state_t            state;
   state_t            stateNext;
   state_t            resumeState;
   logic [2:0]        rinseCnt;
   logic              skipDry;
   logic [PHASES-1:0] activeMask;
   logic              activeDone;
   logic              timeout;
   logic              wdClear;
   logic              wdEnable;
   logic              wdHold;

   assign activeMask = phaseMask(state);
   assign activeDone = |(bus.PhaseDone & activeMask);

   // A done on the active phase outranks both the door and the watchdog.
   always_comb begin
      stateNext      = state;
      bus.PhaseStart = activeMask;
      bus.Busy       = (state != IDLE) && (state != FAULT);
      bus.Paused     = (state == PAUSE);
      bus.CycleDone  = (state == FINISH);
      bus.Fault      = (state == FAULT);
      bus.State      = state;
      case (state)
         IDLE: if (bus.Go && !bus.DoorOpen) stateNext = FILL;
         FILL, WASH, DRAIN1, RINSE, DRAIN2, SPIN, DRY: begin
            if (activeDone) begin
               case (state)
                  FILL:    stateNext = WASH;
                  WASH:    stateNext = DRAIN1;
                  DRAIN1:  stateNext = RINSE;
                  RINSE:   stateNext = DRAIN2;
                  DRAIN2:  stateNext = (rinseCnt > 3'd1) ? RINSE : SPIN;
                  SPIN:    stateNext = skipDry ? FINISH : DRY;
                  default: stateNext = FINISH;
               endcase
            end else if (bus.DoorOpen)
               stateNext = PAUSE;
            else if (timeout)
               stateNext = FAULT;
         end
         FINISH:  stateNext = IDLE;
         PAUSE:   if (!bus.DoorOpen) stateNext = resumeState;
         FAULT:   stateNext = FAULT;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state       <= IDLE;
         resumeState <= IDLE;
         rinseCnt    <= '0;
         skipDry     <= 1'b0;
      end else begin
         state <= stateNext;
         if (state == IDLE && stateNext == FILL) begin
            rinseCnt <= 3'(RINSE_COUNT);
            skipDry  <= bus.NoDry;
         end
         if (state == DRAIN2 && activeDone)
            rinseCnt <= rinseCnt - 3'd1;
         if (stateNext == PAUSE && state != PAUSE)
            resumeState <= state;
      end
   end

   // Entering PAUSE keeps the count; every other state entry restarts it.
   assign wdClear  = (stateNext != state) && (stateNext != PAUSE);
   assign wdEnable = |activeMask;
   assign wdHold   = (state == PAUSE);

   phase_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) watchdog (
      .CLK     (CLK),
      .Reset   (Reset),
      .clear   (wdClear),
      .enable  (wdEnable),
      .hold    (wdHold),
      .timeout (timeout)
   );

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: a per-cycle vector table, then
// responder-driven sequences for full cycles, pause, watchdog and reset.
module tb_wash_sequencer;

   typedef struct {
      string      name;
      logic [3:0] ctl;
      logic [5:0] done;
      logic [3:0] state;
      logic [5:0] start;
      logic [3:0] flags;
   } vec_t;

   logic   CLK = 1'b0;
   logic   Reset;
   int     compared = 0;
   int     mismatched = 0;
   int     cdPulses = 0;
   int     dryCycles = 0;
   vec_t   vecs[$];

   wash_if bus();

   wash_sequencer #(
      .RINSE_COUNT (2),
      .TIMEOUT     (50),
      .TW          (6)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (bus.CycleDone) cdPulses++;
      if (bus.PhaseStart[5]) dryCycles++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] ctl, input logic [5:0] done);
      {Reset, bus.Go, bus.NoDry, bus.DoorOpen} = ctl;
      bus.PhaseDone = done;
      tick();
   endtask

   task automatic addVec(input string n, input logic [3:0] ctl, input logic [5:0] done,
                         input logic [3:0] st, input logic [5:0] start, input logic [3:0] flags);
      vec_t v;
      v.name = n; v.ctl = ctl; v.done = done; v.state = st; v.start = start; v.flags = flags;
      vecs.push_back(v);
   endtask

   function automatic logic [15:0] observed();
      return {2'b00, bus.State, bus.PhaseStart, bus.Busy, bus.Paused, bus.CycleDone, bus.Fault};
   endfunction

   task automatic startCycle(input logic noDry);
      applyStimulus(4'b1000, 6'h00);
      repeat (4) applyStimulus(4'b0000, 6'h00);
      applyStimulus({2'b01, noDry, 1'b0}, 6'h00);
      {Reset, bus.Go, bus.NoDry, bus.DoorOpen} = 4'b0000;
   endtask

   // Responder: checks Start just rose, answers done 20 cycles after the rise.
   task automatic doPhase(input int b, input string tag);
      logic [5:0] oh;
      oh = 6'(1) << b;
      checkOutput({tag, " start rise"}, {10'b0, bus.PhaseStart}, {10'b0, oh});
      repeat (19) tick();
      checkOutput({tag, " start held"}, {9'b0, bus.Busy, bus.PhaseStart}, {9'b0, 1'b1, oh});
      bus.PhaseDone = oh;
      tick();
      bus.PhaseDone = 6'h00;
   endtask

   initial begin
      int order[9];
      int base;
      int pauseGood;
      order = '{0, 1, 2, 3, 2, 3, 2, 4, 5};
      Reset = 1'b1;
      bus.Go = 1'b0; bus.NoDry = 1'b0; bus.DoorOpen = 1'b0; bus.PhaseDone = 6'h00;

      // ctl = {Reset, Go, NoDry, DoorOpen}; flags = {Busy, Paused, CycleDone, Fault}
      addVec("reset",          4'b1000, 6'h00, 4'd0, 6'h00, 4'b0000);
      addVec("go door open",   4'b0101, 6'h00, 4'd0, 6'h00, 4'b0000);
      addVec("go",             4'b0100, 6'h00, 4'd1, 6'h01, 4'b1000);
      addVec("stray dry done", 4'b0000, 6'h20, 4'd1, 6'h01, 4'b1000);
      addVec("go while busy",  4'b0100, 6'h00, 4'd1, 6'h01, 4'b1000);
      addVec("fill done+door", 4'b0001, 6'h01, 4'd2, 6'h02, 4'b1000);
      addVec("pause entry",    4'b0001, 6'h00, 4'd9, 6'h00, 4'b1100);
      addVec("pause hold",     4'b0001, 6'h00, 4'd9, 6'h00, 4'b1100);
      addVec("resume wash",    4'b0000, 6'h00, 4'd2, 6'h02, 4'b1000);
      addVec("wash done",      4'b0000, 6'h02, 4'd3, 6'h04, 4'b1000);
      addVec("drain1 done",    4'b0000, 6'h04, 4'd4, 6'h08, 4'b1000);
      addVec("rinse1 done",    4'b0000, 6'h08, 4'd5, 6'h04, 4'b1000);
      addVec("drain2a done",   4'b0000, 6'h04, 4'd4, 6'h08, 4'b1000);
      addVec("rinse2 done",    4'b0000, 6'h08, 4'd5, 6'h04, 4'b1000);
      addVec("drain2 pause",   4'b0001, 6'h00, 4'd9, 6'h00, 4'b1100);
      addVec("drain2 resume",  4'b0000, 6'h00, 4'd5, 6'h04, 4'b1000);
      addVec("drain2b done",   4'b0000, 6'h04, 4'd6, 6'h10, 4'b1000);
      addVec("spin done",      4'b0000, 6'h10, 4'd7, 6'h20, 4'b1000);
      addVec("dry done",       4'b0000, 6'h20, 4'd8, 6'h00, 4'b1010);
      addVec("back to idle",   4'b0000, 6'h00, 4'd0, 6'h00, 4'b0000);
      addVec("go nodry",       4'b0110, 6'h00, 4'd1, 6'h01, 4'b1000);
      addVec("reset in fill",  4'b1000, 6'h00, 4'd0, 6'h00, 4'b0000);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].ctl, vecs[i].done);
         checkOutput(vecs[i].name, observed(),
                     {2'b00, vecs[i].state, vecs[i].start, vecs[i].flags});
      end

      // Nominal full cycle with a 20-cycle responder.
      startCycle(1'b0);
      base = cdPulses;
      for (int i = 0; i < 9; i++) doPhase(order[i], $sformatf("nominal ph%0d", i));
      checkOutput("nominal finish", observed(), {2'b00, 4'd8, 6'h00, 4'b1010});
      tick();
      checkOutput("nominal idle", observed(), 16'h0000);
      checkOutput("nominal cycledone count", 16'(cdPulses - base), 16'd1);

      // NoDry: FINISH straight after SPIN.
      startCycle(1'b1);
      base = dryCycles;
      for (int i = 0; i < 8; i++) doPhase(order[i], $sformatf("nodry ph%0d", i));
      checkOutput("nodry finish", observed(), {2'b00, 4'd8, 6'h00, 4'b1010});
      tick();
      checkOutput("nodry dry cycles", 16'(dryCycles - base), 16'd0);

      // Door open for 15 cycles starting at cycle 10 of WASH.
      startCycle(1'b0);
      doPhase(0, "pause fill");
      repeat (9) tick();
      bus.DoorOpen = 1'b1;
      pauseGood = 0;
      repeat (15) begin
         tick();
         if (bus.PhaseStart == 6'h00 && bus.Paused && bus.Busy) pauseGood++;
      end
      checkOutput("pause cycles", 16'(pauseGood), 16'd15);
      bus.DoorOpen = 1'b0;
      tick();
      doPhase(1, "pause wash restart");
      checkOutput("pause drain1", observed(), {2'b00, 4'd3, 6'h04, 4'b1000});

      // Watchdog: SPIN never answered.
      startCycle(1'b0);
      for (int i = 0; i < 7; i++) doPhase(order[i], $sformatf("wd ph%0d", i));
      checkOutput("wd spin start", observed(), {2'b00, 4'd6, 6'h10, 4'b1000});
      repeat (49) tick();
      checkOutput("wd spin cycle 50", observed(), {2'b00, 4'd6, 6'h10, 4'b1000});
      tick();
      checkOutput("wd fault", observed(), {2'b00, 4'd10, 6'h00, 4'b0001});
      bus.Go = 1'b1;
      repeat (3) tick();
      bus.Go = 1'b0;
      checkOutput("wd go ignored", observed(), {2'b00, 4'd10, 6'h00, 4'b0001});
      applyStimulus(4'b1000, 6'h00);
      Reset = 1'b0;
      checkOutput("wd reset clears", observed(), 16'h0000);

      // Reset in the second RINSE, then a fresh full cycle.
      startCycle(1'b0);
      for (int i = 0; i < 5; i++) doPhase(order[i], $sformatf("rst ph%0d", i));
      repeat (5) tick();
      checkOutput("rst in rinse", observed(), {2'b00, 4'd4, 6'h08, 4'b1000});
      applyStimulus(4'b1000, 6'h00);
      checkOutput("rst abort", observed(), 16'h0000);
      applyStimulus(4'b0000, 6'h00);
      applyStimulus(4'b0100, 6'h00);
      bus.Go = 1'b0;
      for (int i = 0; i < 9; i++) doPhase(order[i], $sformatf("restart ph%0d", i));
      checkOutput("restart finish", observed(), {2'b00, 4'd8, 6'h00, 4'b1010});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
